// File: rtl/fetch_queue_param.sv
// fetch_queue_param
//   Instruction fetch queue between instruction memory/PC and the IF/ID
//   pipeline register. Buffers {instruction, PC} pairs in a first-word-
//   fall-through FIFO so that ID stalls do not stall fetch. A redirect
//   (flush) empties the queue, optionally retaining the oldest surviving
//   entry as the branch delay slot.
// Ports
//   Clk          clock, rising edge
//   R            synchronous active-high reset, priority over all inputs
//   in_valid     fetch side offers {in_instr, in_pc}
//   in_ready     queue can accept (count < DEPTH)
//   in_instr     fetched instruction
//   in_pc        PC of fetched instruction
//   out_valid    head entry present (count != 0)
//   out_ready    ID side consumes head this cycle
//   out_instr    head instruction, 0 when empty
//   out_pc       head PC, 0 when empty
//   flush        redirect: drop queued entries and this cycle's push
//   flush_keep   with flush: keep oldest entry remaining after pop
//   count        current occupancy
//   almost_full  count >= AF_LEVEL
module fetch_queue_param #(
   parameter int IW       = 32,
   parameter int AW       = 32,
   parameter int DEPTH    = 4,
   parameter int AF_LEVEL = DEPTH - 1
) (
   input  logic                       Clk,
   input  logic                       R,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [IW-1:0]              in_instr,
   input  logic [AW-1:0]              in_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [IW-1:0]              out_instr,
   output logic [AW-1:0]              out_pc,
   input  logic                       flush,
   input  logic                       flush_keep,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       almost_full
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PARTIAL = 2'd1,
      FULL    = 2'd2
   } state_t;

   state_t        state_q, state_n;
   logic [CW-1:0] count_q, count_n;
   logic [PW-1:0] rd_q, rd_n, wr_q, wr_n;
   logic [PW-1:0] rd_adv;
   logic [CW-1:0] remain;
   logic          push, pop;

   logic [IW-1:0] mem_instr [DEPTH];
   logic [AW-1:0] mem_pc    [DEPTH];

   // State register
   always_ff @(posedge Clk) begin
      if (R) begin
         state_q <= EMPTY;
         count_q <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
      end else begin
         state_q <= state_n;
         count_q <= count_n;
         rd_q    <= rd_n;
         wr_q    <= wr_n;
      end
   end

   // Storage is never cleared; a flushed push is not written.
   always_ff @(posedge Clk) begin
      if (push && !flush && !R) begin
         mem_instr[wr_q] <= in_instr;
         mem_pc[wr_q]    <= in_pc;
      end
   end

   // Next-state logic
   always_comb begin
      push    = in_valid & in_ready;
      pop     = out_valid & out_ready;
      rd_adv  = pop ? rd_q + PTR_ONE : rd_q;
      remain  = pop ? count_q - CNT_ONE : count_q;
      rd_n    = rd_adv;
      wr_n    = push ? wr_q + PTR_ONE : wr_q;
      count_n = push ? remain + CNT_ONE : remain;
      // Flush sees the queue after this cycle's pop; the push is discarded.
      if (flush) begin
         if (flush_keep && (remain != '0)) begin
            count_n = CNT_ONE;
            wr_n    = rd_adv + PTR_ONE;
         end else begin
            count_n = '0;
            wr_n    = rd_adv;
         end
      end
      if (count_n == '0) begin
         state_n = EMPTY;
      end else if (count_n == DEPTH_C) begin
         state_n = FULL;
      end else begin
         state_n = PARTIAL;
      end
   end

   // Outputs: functions of registered state/count only
   always_comb begin
      out_valid   = (state_q != EMPTY);
      in_ready    = (state_q != FULL);
      almost_full = (count_q >= AF_C);
      count       = count_q;
      out_instr   = '0;
      out_pc      = '0;
      if (out_valid) begin
         out_instr = mem_instr[rd_q];
         out_pc    = mem_pc[rd_q];
      end
   end

endmodule

// File: tb/tb_fetch_queue_param.sv
// tb_fetch_queue_param
//   Self-checking bench for fetch_queue_param (DEPTH=4, AF_LEVEL=3).
//   A queue of expected {instr, pc} pairs is pushed when stimulus offers an
//   accepted word and popped/compared when the DUT hands its head over.
module tb_fetch_queue_param;

   localparam int IW    = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 4;
   localparam int AF    = 3;

   logic          clk = 1'b0;
   logic          r = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [IW-1:0] in_instr = '0;
   logic [AW-1:0] in_pc = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [IW-1:0] out_instr;
   logic [AW-1:0] out_pc;
   logic          flush = 1'b0;
   logic          flush_keep = 1'b0;
   logic [2:0]    count;
   logic          almost_full;

   typedef struct {
      logic [IW-1:0] instr;
      logic [AW-1:0] pc;
   } entry_t;

   entry_t sb[$];
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   fetch_queue_param #(
      .IW(IW), .AW(AW), .DEPTH(DEPTH), .AF_LEVEL(AF)
   ) dut (
      .Clk(clk), .R(r),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc),
      .flush(flush), .flush_keep(flush_keep),
      .count(count), .almost_full(almost_full)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // One clock: drive inputs, compare popped head before the edge, update
   // the expected queue, then compare status after the edge.
   task automatic cycle(input logic iv, input logic [IW-1:0] ins, input logic [AW-1:0] pc,
                        input logic ordy, input logic fl, input logic fk, input logic rst);
      bit    exp_push, exp_pop;
      entry_t e;
      r = rst; in_valid = iv; in_instr = ins; in_pc = pc;
      out_ready = ordy; flush = fl; flush_keep = fk;
      #1;
      exp_push = iv && (sb.size() < DEPTH);
      exp_pop  = ordy && (sb.size() > 0);
      if (!rst && exp_pop) begin
         check("pop_instr", 64'(out_instr), 64'(sb[0].instr));
         check("pop_pc", 64'(out_pc), 64'(sb[0].pc));
      end
      @(posedge clk);
      if (rst) begin
         sb.delete();
      end else begin
         if (exp_pop) void'(sb.pop_front());
         if (fl) begin
            if (fk && sb.size() > 0) begin
               e = sb[0];
               sb.delete();
               sb.push_back(e);
            end else begin
               sb.delete();
            end
         end else if (exp_push) begin
            e.instr = ins; e.pc = pc;
            sb.push_back(e);
         end
      end
      #1;
      r = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; flush_keep = 1'b0;
      check("count", 64'(count), 64'(sb.size()));
      check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
      check("in_ready", 64'(in_ready), 64'(sb.size() < DEPTH));
      check("almost_full", 64'(almost_full), 64'(sb.size() >= AF));
      if (sb.size() == 0) begin
         check("empty_instr", 64'(out_instr), 64'h0);
         check("empty_pc", 64'(out_pc), 64'h0);
      end else begin
         check("head_instr", 64'(out_instr), 64'(sb[0].instr));
         check("head_pc", 64'(out_pc), 64'(sb[0].pc));
      end
   endtask

   initial begin
      #2;
      // Reset
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("rst_count", 64'(count), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // Fill with five offers; the fifth is refused
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 32'hA0 + 32'(i), 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b0);
         if (i == 2) check("af_at_3", 64'(almost_full), 64'd1);
      end
      check("full_count", 64'(count), 64'd4);
      check("full_in_ready", 64'(in_ready), 64'd0);
      for (int i = 0; i < 4; i++) begin
         #0 check("fill_order", 64'(out_instr), 64'(32'hA0 + 32'(i)));
         cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      end

      // Wrap: hold count at 2 with simultaneous push and pop
      cycle(1'b1, 32'hC0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'hC1, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 2; i < 12; i++) begin
         cycle(1'b1, 32'hC0 + 32'(i), 32'h100 + 32'(4 * i), 1'b1, 1'b0, 1'b0, 1'b0);
         check("wrap_count", 64'(count), 64'd2);
      end
      cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Flush drop with a push in the same cycle
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'hB0 + 32'(i), 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'hB3, 32'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      check("flush_drop_count", 64'(count), 64'd0);

      // Flush keep with pop: delay slot is 0xB1
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'hB0 + 32'(i), 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'hB3, 32'd3, 1'b1, 1'b1, 1'b1, 1'b0);
      check("keep_pop_count", 64'(count), 64'd1);
      check("keep_pop_head", 64'(out_instr), 64'hB1);
      // Flush keep with pop at count 1 leaves nothing
      cycle(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
      check("keep_last_count", 64'(count), 64'd0);

      // Flush keep without pop: delay slot is 0xB0
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'hB0 + 32'(i), 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
      check("keep_nopop_head", 64'(out_instr), 64'hB0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Random traffic with occasional redirects
      for (int i = 0; i < 200; i++) begin
         logic fl;
         fl = ($urandom_range(0, 15) == 0);
         cycle(1'($urandom_range(0, 3) != 0), $urandom(), $urandom(),
               1'($urandom_range(0, 1)), fl, 1'($urandom_range(0, 1)), 1'b0);
      end

      // Reset mid-operation overrides push, pop and flush
      for (int i = 0; i < 5; i++) cycle(1'b1, 32'hD0 + 32'(i), 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      check("pre_rst_count", 64'(count), 64'd4);
      cycle(1'b1, 32'hDF, 32'hF, 1'b1, 1'b1, 1'b1, 1'b1);
      check("mid_rst_count", 64'(count), 64'd0);
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_in_ready", 64'(in_ready), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
